ir_queue: RTL and testbench

//  Parametrised instruction register fronted by a small prefetch queue.

---
 rtl/ir_queue_pkg.sv | 14 +
 rtl/ir_queue_mem.sv | 25 ++
 rtl/ir_queue.sv | 121 ++++++++++++
 tb/tb_ir_queue.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ir_queue_pkg.sv
// Shared definitions for the instruction-register prefetch queue:
// default geometry, rIR reset value and the count-width helper.
package ir_queue_pkg;

  localparam int unsigned IR_DEF_WIDTH = 8;
  localparam int unsigned IR_DEF_DEPTH = 4;
  localparam int unsigned IR_RESET_VAL = 0;

  // Bits needed to hold 0..depth inclusive.
  function automatic int unsigned irCountWidth(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ir_queue_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
module ir_queue_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ir_queue.sv
// Instruction register fronted by a prefetch queue with flush and sticky
// overflow/underflow flags.
// Optional build macro IR_QUEUE_BYPASS_EN: when the queue is empty and push
// and wIR coincide, nIR goes straight into rIR without being stored.
module ir_queue
  import ir_queue_pkg::*;
#(
  parameter int unsigned WIDTH = IR_DEF_WIDTH,
  parameter int unsigned DEPTH = IR_DEF_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 nIR,
  input  logic                             wIR,
  output logic [WIDTH-1:0]                 rIR,
  output logic [WIDTH-1:0]                 head,
  output logic                             empty,
  output logic                             full,
  output logic [irCountWidth(DEPTH)-1:0]   count,
  output logic                             ovf,
  output logic                             udf
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = irCountWidth(DEPTH);

  logic [PtrW-1:0]  rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
  logic [CntW-1:0]  countQ, countD;
  logic [WIDTH-1:0] rIRQ, rIRD, rdData;
  logic             ovfQ, ovfD, udfQ, udfD;
  logic             popEn, pushEn, bypass;

  assign empty = (countQ == '0);
  assign full  = (countQ == CntW'(DEPTH));

`ifdef IR_QUEUE_BYPASS_EN
  assign bypass = !flush & empty & push & wIR;
`else
  assign bypass = 1'b0;
`endif

  assign popEn  = !flush & wIR & !empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign pushEn = !flush & push & !bypass & (!full | popEn);

  ir_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) uMem (
    .clk     (clk),
    .wr_en   (pushEn),
    .wr_addr (wrPtrQ),
    .wr_data (nIR),
    .rd_addr (rdPtrQ),
    .rd_data (rdData)
  );

  // Next-state: pointers, count, rIR and sticky flags.
  always_comb begin
    rdPtrD = rdPtrQ;
    wrPtrD = wrPtrQ;
    countD = countQ;
    rIRD   = rIRQ;
    ovfD   = ovfQ;
    udfD   = udfQ;
    if (flush) begin
      rdPtrD = '0;
      wrPtrD = '0;
      countD = '0;
    end else begin
      if (popEn) begin
        rdPtrD = rdPtrQ + 1'b1;
        rIRD   = rdData;
      end else if (bypass) begin
        rIRD = nIR;
      end
      if (pushEn) begin
        wrPtrD = wrPtrQ + 1'b1;
      end
      unique case ({pushEn, popEn})
        2'b10:   countD = countQ + 1'b1;
        2'b01:   countD = countQ - 1'b1;
        default: countD = countQ;
      endcase
      if (push && full && !popEn) begin
        ovfD = 1'b1;
      end
      if (wIR && empty && !bypass) begin
        udfD = 1'b1;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtrQ <= '0;
      wrPtrQ <= '0;
      countQ <= '0;
      rIRQ   <= WIDTH'(IR_RESET_VAL);
      ovfQ   <= 1'b0;
      udfQ   <= 1'b0;
    end else begin
      rdPtrQ <= rdPtrD;
      wrPtrQ <= wrPtrD;
      countQ <= countD;
      rIRQ   <= rIRD;
      ovfQ   <= ovfD;
      udfQ   <= udfD;
    end
  end

  assign head  = empty ? '0 : rdData;
  assign rIR   = rIRQ;
  assign count = countQ;
  assign ovf   = ovfQ;
  assign udf   = udfQ;

endmodule

// File: tb/tb_ir_queue.sv
// Directed self-checking bench for ir_queue (WIDTH=8, DEPTH=4).
module tb_ir_queue;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n, flush, push, wIR;
  logic [WIDTH-1:0] nIR, rIR, head;
  logic             empty, full, ovf, udf;
  logic [2:0]       count;

  int nChecks = 0;
  int nErrors = 0;

  ir_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .nIR   (nIR),
    .wIR   (wIR),
    .rIR   (rIR),
    .head  (head),
    .empty (empty),
    .full  (full),
    .count (count),
    .ovf   (ovf),
    .udf   (udf)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    push  = 1'b0;
    wIR   = 1'b0;
    nIR   = '0;
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    checkVal("rst_rIR", rIR, 0);
    checkVal("rst_count", count, 0);
    checkVal("rst_empty", empty, 1);
    checkVal("rst_head", head, 0);
    checkVal("rst_flags", {ovf, udf}, 0);
    rst_n = 1'b1;

    // 1: push two, load one
    push = 1'b1; nIR = 8'h10; tick();
    checkVal("t1_head_vis", head, 8'h10);
    nIR = 8'h20; tick();
    idle(); wIR = 1'b1; tick();
    checkVal("t1_rIR", rIR, 8'h10);
    checkVal("t1_count", count, 1);
    checkVal("t1_head", head, 8'h20);
    tick();
    idle();
    checkVal("t1_drain", rIR, 8'h20);
    checkVal("t1_empty", empty, 1);

    // 2: fill, overflow, push+pop while full
    for (int i = 1; i <= 4; i++) begin
      push = 1'b1; nIR = 8'(i); tick();
    end
    checkVal("t2_full", full, 1);
    checkVal("t2_ovf_pre", ovf, 0);
    nIR = 8'h05; tick();
    checkVal("t2_ovf", ovf, 1);
    checkVal("t2_head", head, 8'h01);
    checkVal("t2_count", count, 4);
    wIR = 1'b1; tick();
    checkVal("t2_rIR", rIR, 8'h01);
    checkVal("t2_count_pp", count, 4);
    checkVal("t2_head_pp", head, 8'h02);
    push = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      tick();
      checkVal("t2_drain", rIR, 32'(i));
    end
    idle();
    checkVal("t2_empty", empty, 1);

    // 3: underflow holds rIR, reset clears flags
    wIR = 1'b1; tick(); idle();
    checkVal("t3_rIR_held", rIR, 8'h05);
    checkVal("t3_udf", udf, 1);
    resetPulse();
    checkVal("t3_udf_clr", udf, 0);
    checkVal("t3_ovf_clr", ovf, 0);
    checkVal("t3_rIR_rst", rIR, 0);

    // 4: flush overrides push and wIR
    push = 1'b1; nIR = 8'h0A; tick();
    wIR = 1'b1; nIR = 8'h0B; tick();
    wIR = 1'b0; nIR = 8'h0C; tick();
    nIR = 8'h0D; tick();
    checkVal("t4_count_pre", count, 3);
    flush = 1'b1; push = 1'b1; wIR = 1'b1; nIR = 8'hFF; tick(); idle();
    checkVal("t4_count", count, 0);
    checkVal("t4_empty", empty, 1);
    checkVal("t4_rIR", rIR, 8'h0A);
    checkVal("t4_flags", {ovf, udf}, 0);

    // 5: streaming push/pop, pointers wrap several times
    push = 1'b1; nIR = 8'h00; tick();
    wIR = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      nIR = 8'(i + 1); tick();
      checkVal("t5_rIR", rIR, 32'(i));
      checkVal("t5_count", count, 1);
    end
    push = 1'b0; tick(); idle();
    checkVal("t5_last", rIR, 3 * DEPTH);
    checkVal("t5_empty", empty, 1);
    checkVal("t5_flags", {ovf, udf}, 0);

    // 6: empty queue, push with wIR
    push = 1'b1; wIR = 1'b1; nIR = 8'h30; tick(); idle();
`ifdef IR_QUEUE_BYPASS_EN
    checkVal("t6_rIR", rIR, 8'h30);
    checkVal("t6_count", count, 0);
    checkVal("t6_udf", udf, 0);
`else
    checkVal("t6_rIR", rIR, 3 * DEPTH);
    checkVal("t6_udf", udf, 1);
    checkVal("t6_count", count, 1);
    checkVal("t6_head", head, 8'h30);
`endif

    // 7: async reset with queue full, between edges
    resetPulse();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; nIR = 8'(8'h40 + i); tick();
    end
    idle();
    wIR = 1'b1; tick(); wIR = 1'b0;
    push = 1'b1; nIR = 8'h50; tick(); idle();
    checkVal("t7_full", full, 1);
    checkVal("t7_rIR_pre", rIR, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("t7_count", count, 0);
    checkVal("t7_empty", empty, 1);
    checkVal("t7_notfull", full, 0);
    checkVal("t7_head", head, 0);
    checkVal("t7_rIR", rIR, 0);
    checkVal("t7_flags", {ovf, udf}, 0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
